// File: rtl/omsp_spm_protect_seq_if.sv
// Request/SPM-control/key-source signals of the protect sequencer.
// master = sequencer side, slave = environment (decode, control array, key source).
interface omsp_spm_protect_seq_if #(
  parameter int KEY_IDX_SIZE = 2
);
  logic                    start;
  logic                    start_enable;
  logic                    violation;
  logic                    key_sel_valid;
  logic                    kd_valid;
  logic [15:0]             kd_data;
  logic                    kd_ready;
  logic                    update_spm;
  logic                    enable_spm;
  logic [15:0]             spm_key_select;
  logic                    write_key;
  logic [15:0]             key_in;
  logic [KEY_IDX_SIZE-1:0] key_idx;
  logic                    busy;
  logic                    done;
  logic [1:0]              status;
  logic [15:0]             result_id;

  modport master (
    input  start, start_enable, violation, key_sel_valid, kd_valid, kd_data,
    output kd_ready, update_spm, enable_spm, spm_key_select, write_key,
           key_in, key_idx, busy, done, status, result_id
  );

  modport slave (
    output start, start_enable, violation, key_sel_valid, kd_valid, kd_data,
    input  kd_ready, update_spm, enable_spm, spm_key_select, write_key,
           key_in, key_idx, busy, done, status, result_id
  );
endinterface

// File: rtl/omsp_spm_protect_seq.sv
// Sequences one SPM protect/unprotect: update pulse, violation/slot check, key streaming.
// Key words land one cycle after their kd handshake; new starts are dropped while busy.
module omsp_spm_protect_seq #(
  parameter int SECURITY     = 64,
  parameter int KEY_IDX_SIZE = 2,
  parameter int KEY_TIMEOUT  = 255
) (
  input  logic                   mclk,
  input  logic                   puc_rst_n,
  omsp_spm_protect_seq_if.master bus
);
  localparam int                      NWORDS    = SECURITY / 16;
  localparam logic [KEY_IDX_SIZE-1:0] LAST_WORD = KEY_IDX_SIZE'(NWORDS - 1);
  localparam logic [7:0]              TMO_LAST  = 8'(KEY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, UPDATE, CHECK, KEY, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    en_q;
  logic                    viol_q;
  logic [15:0]             cur_id;
  logic [15:0]             shadow_id;
  logic [KEY_IDX_SIZE-1:0] word_cnt;
  logic [7:0]              tmo_cnt;
  logic [1:0]              status_nxt;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    status_nxt = 2'd0;
    case (state)
      IDLE:   if (bus.start) state_nxt = UPDATE;
      UPDATE: state_nxt = CHECK;
      CHECK: begin
        if (viol_q | bus.violation) begin
          state_nxt  = DONE;
          status_nxt = 2'd1;
        end else if (!en_q) begin
          state_nxt  = DONE;
        end else if (!bus.key_sel_valid) begin
          state_nxt  = DONE;
          status_nxt = 2'd2;
        end else begin
          state_nxt  = KEY;
        end
      end
      KEY: begin
        if (bus.violation) begin
          state_nxt  = DONE;
          status_nxt = 2'd1;
        end else if (bus.kd_valid) begin
          if (word_cnt == LAST_WORD) state_nxt = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt  = DONE;
          status_nxt = 2'd3;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.update_spm     = 1'b0;
    bus.enable_spm     = 1'b0;
    bus.kd_ready       = 1'b0;
    bus.spm_key_select = 16'h0000;
    bus.done           = 1'b0;
    bus.busy           = (state != IDLE);
    case (state)
      UPDATE: begin
        bus.update_spm = 1'b1;
        bus.enable_spm = en_q;
      end
      CHECK:  bus.spm_key_select = cur_id;
      KEY: begin
        bus.spm_key_select = cur_id;
        bus.kd_ready       = 1'b1;
      end
      DONE:   bus.done = 1'b1;
      default: ;
    endcase
  end

  // shadow_id tracks the control array's next-ID counter, so it must bump on
  // every protect update even when the array flags a violation.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      en_q          <= 1'b0;
      viol_q        <= 1'b0;
      cur_id        <= 16'h0000;
      shadow_id     <= 16'h0001;
      word_cnt      <= '0;
      tmo_cnt       <= 8'd0;
      bus.status    <= 2'd0;
      bus.result_id <= 16'h0000;
      bus.write_key <= 1'b0;
      bus.key_in    <= 16'h0000;
      bus.key_idx   <= '0;
    end else begin
      bus.write_key <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            en_q   <= bus.start_enable;
            cur_id <= shadow_id;
          end
        end
        UPDATE: begin
          viol_q <= bus.violation;
          if (en_q) shadow_id <= shadow_id + 16'd1;
        end
        CHECK: begin
          word_cnt <= '0;
          tmo_cnt  <= 8'd0;
        end
        KEY: begin
          // A word handshaken in the same cycle as a violation is discarded.
          if (!bus.violation) begin
            if (bus.kd_valid) begin
              bus.write_key <= 1'b1;
              bus.key_in    <= bus.kd_data;
              bus.key_idx   <= word_cnt;
              word_cnt      <= word_cnt + 1'b1;
              tmo_cnt       <= 8'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
      if (state != DONE && state_nxt == DONE) begin
        bus.status    <= status_nxt;
        bus.result_id <= en_q ? cur_id : 16'h0000;
      end
    end
  end
endmodule
